// File: rtl/pc_branch_unit.sv
// IF-stage PC register and IF/ID pipeline register with branch/jump redirect.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction on redirect.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_sh,
  input  logic [31:0] pc_plus4_id,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        redirect
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        redirect_q, redirect_d;

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        take_j;
  logic        take_b;
  logic        take_any;

  assign pc_plus4       = pc_q + 32'd4;
  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign redirect       = redirect_q;

  // Targets and qualified redirect requests (bubbles and stalls never redirect)
  always_comb begin
    branch_target = pc_plus4_id + branch_offset_sh;
    jump_target   = {pc_plus4_id[31:28], jump_index, 2'b00};
    take_j        = jump & valid_q & ~stall;
    take_b        = branch_taken & valid_q & ~stall & ~jump;
    take_any      = take_j | take_b;
  end

  // Next fetch address: jump beats branch, then stall hold, then sequential
  always_comb begin
    pc_d = pc_plus4;
    unique case (1'b1)
      take_j:  pc_d = jump_target;
      take_b:  pc_d = branch_target;
      stall:   pc_d = pc_q;
      default: pc_d = pc_plus4;
    endcase
  end

  // Sequencer: IF/ID load, flush bubble and redirect pulse
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    redirect_d = 1'b0;
    unique case (state_q)
      BOOT: begin
        if (!stall) begin
          instr_d = instr_in;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (take_any) begin
          redirect_d = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
          instr_d = instr_in;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          state_d = RUN;
`else
          instr_d = NOP_INSTR;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
          state_d = FLUSH;
`endif
        end else if (!stall) begin
          instr_d = instr_in;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
      FLUSH: begin
        if (!stall) begin
          instr_d = instr_in;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers, asynchronously reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: expected IF-stage state is queued when
// stimulus is driven and compared after the following clock edge.
module tb_pc_branch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] instr_in;
  logic        branch_taken;
  logic [31:0] branch_offset_sh;
  logic [31:0] pc_plus4_id;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        redirect;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        redir;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_branch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .instr_in        (instr_in),
    .branch_taken    (branch_taken),
    .branch_offset_sh(branch_offset_sh),
    .pc_plus4_id     (pc_plus4_id),
    .jump            (jump),
    .jump_index      (jump_index),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .redirect        (redirect)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] p,
                      input logic [31:0] i, input logic [31:0] p4,
                      input logic v, input logic r);
    exp_t e;
    e.tag = tag; e.pc = p; e.instr = i;
    e.pc4 = p4; e.valid = v; e.redir = r;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"}, pc, e.pc);
      chk({e.tag, ".instr"}, if_id_instr, e.instr);
      chk({e.tag, ".pc4"}, if_id_pc_plus4, e.pc4);
      chk({e.tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
      chk({e.tag, ".redir"}, {31'd0, redirect}, {31'd0, e.redir});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; jump = 0;
    branch_offset_sh = 0; pc_plus4_id = 0; jump_index = 0;
  endtask

  initial begin
    reset = 1'b1;
    instr_in = 32'h2008_0005;
    idle_inputs();
    #2;
    push("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    compare_head();

    // 1: boot and sequential fetch
    @(negedge clk);
    reset = 1'b0;
    push("boot", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0);
    tick();
    push("seq", 32'h8, 32'h2008_0005, 32'h8, 1'b1, 1'b0);
    tick();

    // 2: taken branch, positive offset (pc=8, pc+4=C)
    @(negedge clk);
    instr_in = 32'hAAAA_0001;
    pc_plus4_id = 32'h14; branch_offset_sh = 32'h10; branch_taken = 1;
    push("br_pos", 32'h24, DS ? 32'hAAAA_0001 : 32'h0,
         DS ? 32'hC : 32'h0, DS, 1'b1);
    tick();
    @(negedge clk);
    idle_inputs();
    instr_in = 32'hBBBB_0002;
    push("br_pos_after", 32'h28, 32'hBBBB_0002, 32'h28, 1'b1, 1'b0);
    tick();

    // 3: negative offset (pc=28, pc+4=2C)
    @(negedge clk);
    instr_in = 32'hCCCC_0003;
    pc_plus4_id = 32'h100; branch_offset_sh = 32'hFFFF_FFF0; branch_taken = 1;
    push("br_neg", 32'hF0, DS ? 32'hCCCC_0003 : 32'h0,
         DS ? 32'h2C : 32'h0, DS, 1'b1);
    tick();
    @(negedge clk);
    idle_inputs();
    push("br_neg_after", 32'hF4, 32'hCCCC_0003, 32'hF4, 1'b1, 1'b0);
    tick();

    // 4: jump together with branch_taken -> jump wins (pc=F4, pc+4=F8)
    @(negedge clk);
    pc_plus4_id = 32'h9000_0004; jump_index = 26'h000_0040; jump = 1;
    branch_offset_sh = 32'h10; branch_taken = 1;
    push("jump", 32'h9000_0100, DS ? 32'hCCCC_0003 : 32'h0,
         DS ? 32'hF8 : 32'h0, DS, 1'b1);
    tick();
    @(negedge clk);
    idle_inputs();
    push("jump_after", 32'h9000_0104, 32'hCCCC_0003, 32'h9000_0104,
         1'b1, 1'b0);
    tick();

    // 5: stall three cycles with a pending branch
    @(negedge clk);
    instr_in = 32'hDDDD_0004;
    stall = 1; branch_taken = 1;
    pc_plus4_id = 32'h14; branch_offset_sh = 32'h10;
    for (int k = 0; k < 3; k++) begin
      push("stall", 32'h9000_0104, 32'hCCCC_0003, 32'h9000_0104,
           1'b1, 1'b0);
      tick();
    end
    @(negedge clk);
    stall = 0;
    push("stall_release", 32'h24, DS ? 32'hDDDD_0004 : 32'h0,
         DS ? 32'h9000_0108 : 32'h0, DS, 1'b1);
    tick();
    @(negedge clk);
    idle_inputs();
    push("stall_after", 32'h28, 32'hDDDD_0004, 32'h28, 1'b1, 1'b0);
    tick();

    // 6a: jump to top of address space, then wrap to 0 (pc=28, pc+4=2C)
    @(negedge clk);
    pc_plus4_id = 32'hF000_0000; jump_index = 26'h3FF_FFFF; jump = 1;
    push("jump_top", 32'hFFFF_FFFC, DS ? 32'hDDDD_0004 : 32'h0,
         DS ? 32'h2C : 32'h0, DS, 1'b1);
    tick();
    chk("pc_plus4_wrap", pc_plus4, 32'h0);
    @(negedge clk);
    idle_inputs();
    push("wrap", 32'h0, 32'hDDDD_0004, 32'h0, 1'b1, 1'b0);
    tick();
    chk("pc_plus4_after_wrap", pc_plus4, 32'h4);

    // 6b: branch, then async reset between edges (pc=0, pc+4=4)
    @(negedge clk);
    branch_taken = 1; pc_plus4_id = 32'h14; branch_offset_sh = 32'h10;
    push("br_pre_reset", 32'h24, DS ? 32'hDDDD_0004 : 32'h0,
         DS ? 32'h4 : 32'h0, DS, 1'b1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    push("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    compare_head();
    @(negedge clk);
    idle_inputs();
    instr_in = 32'hEEEE_0005;
    push("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    push("reboot", 32'h4, 32'hEEEE_0005, 32'h4, 1'b1, 1'b0);
    tick();

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
